// File: rtl/iob_merge_pkg.sv
// ============================================================================
// Module  : iob_merge_pkg
// Brief   : Shared types and helpers for the iob_merge native-bus merger.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_merge_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Index width that stays legal when only one master exists
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_rr_arb.sv
// ============================================================================
// Module  : iob_rr_arb
// Brief   : Combinational round-robin search starting after the last grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_rr_arb
  import iob_merge_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  // Offsets 1..N visit every master once, ending on last_i itself
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, last_i} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!any_o && req_i[w_idx]) begin
        grant_o = w_idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_merge.sv
// ============================================================================
// Module  : iob_merge
// Brief   : Merges N native-bus masters onto one slave, one transaction at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_merge
  import iob_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W/8,
  parameter int RESP_W    = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp
);

  localparam int IDX_W = idx_w(N_MASTERS);

  state_t            state_q, state_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  last_q, last_d;

  logic [REQ_W-1:0]  w_req_arr [N_MASTERS];
  logic [N_MASTERS-1:0] w_valid;
  logic [IDX_W-1:0]  w_arb_gnt;
  logic              w_arb_any;
  logic              w_fire;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    localparam logic [IDX_W-1:0] c_idx = IDX_W'(i);
    assign w_req_arr[i] = m_req[i*REQ_W +: REQ_W];
    assign w_valid[i]   = m_req[i*REQ_W + REQ_W - 1];
    assign m_resp[i*RESP_W +: RESP_W] = (w_fire && (gnt_q == c_idx)) ? s_resp : '0;
  end

  iob_rr_arb #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (w_valid),
    .last_i  (last_q),
    .grant_o (w_arb_gnt),
    .any_o   (w_arb_any)
  );

  // req_q is cleared on completion so s_req reads all-zero whenever idle
  assign s_req = req_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    w_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_arb_any) begin
          req_d   = w_req_arr[w_arb_gnt];
          gnt_d   = w_arb_gnt;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (s_resp[0]) begin
          w_fire  = 1'b1;
          last_d  = gnt_q;
          req_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      gnt_q   <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_merge.sv
// ============================================================================
// Module  : tb_iob_merge
// Brief   : Directed self-checking bench for iob_merge with two masters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_merge;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic                clk;
  logic                rst;
  logic [REQ_W-1:0]    w0, w1;
  logic [2*REQ_W-1:0]  m_req;
  logic [2*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]    s_req;
  logic [RESP_W-1:0]   s_resp;

  int n_checks = 0;
  int n_fail   = 0;

  assign m_req = {w1, w0};

  iob_merge #(
    .N_MASTERS (2),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mkreq(input logic v, input logic [31:0] a,
                                             input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; w0 = '0; w1 = '0; s_resp = '0;
    #2;
    n_checks++;
    if (s_req !== '0) begin n_fail++; $display("FAIL reset_sreq: got %h want 0", s_req); end
    n_checks++;
    if (m_resp !== '0) begin n_fail++; $display("FAIL reset_mresp: got %h want 0", m_resp); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_req !== '0 || m_resp !== '0) begin
      n_fail++; $display("FAIL after_reset: s_req %h m_resp %h want 0", s_req, m_resp);
    end
  endtask

  task automatic test_single_read();
    logic [REQ_W-1:0] exp;
    exp = mkreq(1'b1, 32'h100, 32'h0, 4'h0);
    w0 = exp;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (s_req !== exp) begin n_fail++; $display("FAIL single_sreq c%0d: got %h want %h", c, s_req, exp); end
      n_checks++;
      if (m_resp !== '0) begin n_fail++; $display("FAIL single_wait_mresp c%0d: got %h want 0", c, m_resp); end
      if (c < 2) tick();
    end
    s_resp = {32'hDEADBEEF, 1'b1};
    #1;
    n_checks++;
    if (m_resp[32:0] !== {32'hDEADBEEF, 1'b1}) begin
      n_fail++; $display("FAIL single_m0_resp: got %h want %h", m_resp[32:0], {32'hDEADBEEF, 1'b1});
    end
    n_checks++;
    if (m_resp[65:33] !== '0) begin n_fail++; $display("FAIL single_m1_resp: got %h want 0", m_resp[65:33]); end
    tick();
    w0 = '0; s_resp = '0;
    #1;
    n_checks++;
    if (s_req !== '0 || m_resp !== '0) begin
      n_fail++; $display("FAIL single_idle: s_req %h m_resp %h want 0", s_req, m_resp);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [REQ_W-1:0] r0, r1;
    do_reset();
    r0 = mkreq(1'b1, 32'hA000, 32'h11, 4'h3);
    r1 = mkreq(1'b1, 32'hB000, 32'h22, 4'h0);
    w0 = r0; w1 = r1;
    tick();
    n_checks++;
    if (s_req !== r0) begin n_fail++; $display("FAIL cont_first: got %h want %h", s_req, r0); end
    s_resp = {32'h5, 1'b1};
    #1;
    n_checks++;
    if (m_resp !== {33'h0, 32'h5, 1'b1}) begin
      n_fail++; $display("FAIL cont_m0_resp: got %h want %h", m_resp, {33'h0, 32'h5, 1'b1});
    end
    tick();
    w0 = '0; s_resp = '0;
    n_checks++;
    if (s_req !== '0) begin n_fail++; $display("FAIL cont_gap: got %h want 0", s_req); end
    tick();
    n_checks++;
    if (s_req !== r1) begin n_fail++; $display("FAIL cont_second: got %h want %h", s_req, r1); end
    s_resp = {32'h6, 1'b1};
    #1;
    n_checks++;
    if (m_resp !== {32'h6, 1'b1, 33'h0}) begin
      n_fail++; $display("FAIL cont_m1_resp: got %h want %h", m_resp, {32'h6, 1'b1, 33'h0});
    end
    tick();
    w1 = '0; s_resp = '0;
    tick();
  endtask

  task automatic test_fairness();
    logic [REQ_W-1:0] r0, r1, exp;
    logic [31:0] rd;
    r0 = mkreq(1'b1, 32'hC000, 32'h0, 4'h0);
    r1 = mkreq(1'b1, 32'hD000, 32'hFF, 4'hF);
    w0 = r0; w1 = r1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = (k % 2 == 0) ? r0 : r1;
      n_checks++;
      if (s_req !== exp) begin n_fail++; $display("FAIL fair_grant k%0d: got %h want %h", k, s_req, exp); end
      rd = 32'h1000 + 32'(k);
      s_resp = {rd, 1'b1};
      #1;
      n_checks++;
      if ((k % 2 == 0 && m_resp !== {33'h0, rd, 1'b1}) || (k % 2 == 1 && m_resp !== {rd, 1'b1, 33'h0})) begin
        n_fail++; $display("FAIL fair_resp k%0d: got %h rdata want %h", k, m_resp, rd);
      end
      tick();
      s_resp = '0;
    end
    w0 = '0; w1 = '0;
    tick();
  endtask

  task automatic test_write_hold();
    logic [REQ_W-1:0] exp;
    exp = mkreq(1'b1, 32'h40, 32'h12345678, 4'hF);
    w1 = exp;
    tick();
    w1 = mkreq(1'b1, 32'h44, 32'h12345678, 4'hF);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (s_req !== exp) begin n_fail++; $display("FAIL hold_sreq c%0d: got %h want %h", c, s_req, exp); end
      tick();
    end
    s_resp = {32'h0, 1'b1};
    #1;
    n_checks++;
    if (m_resp !== {32'h0, 1'b1, 33'h0}) begin
      n_fail++; $display("FAIL hold_resp: got %h want %h", m_resp, {32'h0, 1'b1, 33'h0});
    end
    tick();
    w1 = '0; s_resp = '0;
    tick();
  endtask

  task automatic test_reset_midop();
    logic [REQ_W-1:0] r0, r1;
    w1 = mkreq(1'b1, 32'h80, 32'h0, 4'h0);
    tick();
    n_checks++;
    if (s_req[REQ_W-1] !== 1'b1) begin n_fail++; $display("FAIL midop_busy: got %b want 1", s_req[REQ_W-1]); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_req !== '0 || m_resp !== '0) begin
      n_fail++; $display("FAIL midop_async: s_req %h m_resp %h want 0", s_req, m_resp);
    end
    w1 = '0;
    tick();
    rst = 1'b0;
    s_resp = {32'hAAAA5555, 1'b1};
    #1;
    n_checks++;
    if (m_resp !== '0 || s_req !== '0) begin
      n_fail++; $display("FAIL midop_late_ready: m_resp %h s_req %h want 0", m_resp, s_req);
    end
    tick();
    s_resp = '0;
    r0 = mkreq(1'b1, 32'hE000, 32'h0, 4'h0);
    r1 = mkreq(1'b1, 32'hF000, 32'h0, 4'h0);
    w0 = r0; w1 = r1;
    tick();
    n_checks++;
    if (s_req !== r0) begin n_fail++; $display("FAIL midop_regrant: got %h want %h", s_req, r0); end
    s_resp = {32'h1, 1'b1};
    tick();
    w0 = '0; w1 = '0; s_resp = '0;
    tick();
  endtask

  task automatic test_spurious();
    s_resp = {32'hFFFFFFFF, 1'b1};
    #1;
    n_checks++;
    if (m_resp !== '0) begin n_fail++; $display("FAIL spur_mresp: got %h want 0", m_resp); end
    tick();
    n_checks++;
    if (m_resp !== '0 || s_req !== '0) begin
      n_fail++; $display("FAIL spur_after: m_resp %h s_req %h want 0", m_resp, s_req);
    end
    s_resp = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_write_hold();
    test_reset_midop();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iob_merge.md
IOB_MERGE -- requirements
Module: iob_merge

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of upstream native-bus masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; byte-strobe width is DATA_W/8.
REQ-004 SHALL define request word REQ_W = 1+ADDR_W+DATA_W+DATA_W/8 as {valid, address, wdata, wstrb} (MSB first), and response word RESP_W = DATA_W+1 as {rdata, ready}.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port m_req, input, N_MASTERS*REQ_W, master requests; master i at slice i.
REQ-008 SHALL have port m_resp, output, N_MASTERS*RESP_W, per-master responses; slice i to master i.
REQ-009 SHALL have port s_req, output, REQ_W, merged request to the single downstream slave.
REQ-010 SHALL have port s_resp, input, RESP_W, response from the downstream slave.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no transaction in flight) and BUSY (one transaction forwarded, awaiting slave ready).
REQ-012 IDLE: if any master valid is 1, SHALL latch the winner's index and full request word into registers and go BUSY on the next edge; otherwise stay IDLE.
REQ-013 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod N_MASTERS and the first valid master wins; last_grant resets to N_MASTERS-1, so master 0 has first priority.
REQ-014 s_req SHALL be driven only from the latched register: valid=1 in BUSY, valid=0 and other fields 0 in IDLE.
REQ-015 Request latency: master valid sampled at edge t -> s_req valid high from cycle t+1.
REQ-016 BUSY: when s_resp ready=1, SHALL drive the granted master's m_resp {rdata, ready=1} combinationally in that cycle, update last_grant to the granted index, and return to IDLE on the next edge.
REQ-017 Non-granted masters SHALL see m_resp = 0 at all times; the granted master SHALL see m_resp = 0 except in the ready cycle.
REQ-018 s_resp ready while IDLE SHALL be ignored (no m_resp ready generated).
REQ-019 At most one transaction SHALL be outstanding; back-to-back from the same or another master costs one IDLE cycle (ready at u -> next s_req valid at u+2).
REQ-020 Master valid deassertion or request-field change while BUSY SHALL NOT affect the forwarded request; the transaction completes with the latched values.
REQ-021 Write (wstrb != 0) and read (wstrb == 0) SHALL be handled identically; rdata is passed through unmodified.

Reset
REQ-022 rst=1 SHALL asynchronously force state=IDLE, request register=0, grant index=0, last_grant=N_MASTERS-1.
REQ-023 During and immediately after reset, s_req and all m_resp SHALL be 0.
REQ-024 Reset asserted in BUSY SHALL abort the in-flight transaction without generating any m_resp ready; a late slave ready after reset is ignored per REQ-018.

Structure
REQ-025 REQ_W/RESP_W field-position macros (valid, address, wdata, wstrb, rdata, ready) SHALL live in the shared iob_lib/iob_intercon include, not in this module.
REQ-026 The round-robin search SHALL be one combinational sub-module, iob_rr_arb (inputs: request vector, last_grant; outputs: grant index, any_req).
REQ-027 FSM, request register and response demux SHALL reside in iob_merge; total 120-400 lines.

Verification
REQ-028 Single read: m0 valid, addr=0x100, wstrb=0; slave ready 3 cycles later with rdata=0xDEADBEEF -> s_req valid 1 cycle after request, m0 ready=1 with rdata=0xDEADBEEF in the slave-ready cycle, m1 resp=0 throughout.
REQ-029 Contention: m0 and m1 valid in the same cycle from reset -> m0 served first, m1 served next with s_req valid exactly 2 cycles after m0's ready.
REQ-030 Fairness: m0 and m1 continuously valid for 8 transactions -> grants alternate 0,1,0,1,... with no starvation.
REQ-031 Write hold: m1 write addr=0x40, wdata=0x12345678, wstrb=0xF, then m1 changes address to 0x44 while BUSY -> slave sees 0x40/0x12345678 until ready.
REQ-032 Reset mid-op: assert rst while BUSY, slave ready 1 cycle later -> no m_resp ready, s_req valid=0, next request granted to master 0.
REQ-033 Spurious slave ready=1 in IDLE with rdata=0xFFFFFFFF -> all m_resp remain 0.
